ex_operand_stage: RTL and testbench
===================================

Name: ex_operand_stage

Overview:
- ID/EX pipeline register directly upstream of the 32-bit ALU (2-bit control: 00 AND, 01 XOR, 10 ADD, 11 SUB).
- Captures decoded operands, resolves operand forwarding from the EX/MEM and MEM/WB stages, and selects the immediate.
- Presents registered alu_a, alu_b and alu_control to the ALU.
- Uses a valid/ready handshake so the pipeline can stall and flush.

Parameters:
- DATA_W, 32, operand and result width (ALU is fixed at 32; other values are not supported).
- REG_AW, 5, register address width.
- IMM_W, 16, immediate field width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  decode has an instruction.
- in_ready  output  1  stage can accept an instruction this cycle.
- rs_addr  input  REG_AW  source register A address.
- rt_addr  input  REG_AW  source register B address.
- rd_addr  input  REG_AW  destination register address.
- rs_data  input  DATA_W  register-file read data A.
- rt_data  input  DATA_W  register-file read data B.
- imm  input  IMM_W  immediate field.
- use_imm  input  1  B operand = extended immediate.
- sign_ext  input  1  1 = sign-extend imm, 0 = zero-extend.
- alu_op  input  2  ALU control code.
- flush  input  1  discard held and incoming instruction.
- mem_we  input  1  EX/MEM stage will write a register.
- mem_waddr  input  REG_AW  EX/MEM destination.
- mem_wdata  input  DATA_W  EX/MEM result.
- wb_we  input  1  MEM/WB stage will write a register.
- wb_waddr  input  REG_AW  MEM/WB destination.
- wb_wdata  input  DATA_W  MEM/WB result.
- out_valid  output  1  registered operands valid.
- out_ready  input  1  downstream consumes this cycle.
- alu_a  output  DATA_W  ALU operand a.
- alu_b  output  DATA_W  ALU operand b.
- alu_control  output  2  ALU control.
- out_rd_addr  output  REG_AW  destination, carried forward.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous, active-high.
- Reset values: out_valid=0, alu_a=0, alu_b=0, alu_control=2'b00, out_rd_addr=0. Reset asserted mid-transfer drops the held instruction; no partial state survives.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - A transfer occurs when in_valid && in_ready; capture happens at the next rising edge, so latency is 1 cycle.
  - If out_valid && !out_ready, all outputs hold stable and in_ready=0.
  - out_valid next state: flush ? 0 : (in_valid && in_ready) ? 1 : (out_ready ? 0 : out_valid).
  - Simultaneous accept and consume: the new instruction replaces the old one in the same edge, giving full throughput.
- Flush:
  - Clears out_valid on the next edge. Data registers may keep stale values.
  - An instruction offered in the flush cycle is not captured.
  - in_ready is unaffected by flush.
- Forwarding (evaluated at capture):
  - fwdA = rs_addr!=0 && mem_we && mem_waddr==rs_addr → mem_wdata.
  - Otherwise rs_addr!=0 && wb_we && wb_waddr==rs_addr → wb_wdata.
  - Otherwise rs_data.
  - Same rules for B using rt_addr and rt_data.
  - EX/MEM has priority over MEM/WB when both match.
  - Register 0 is never forwarded; its data passes through from the register file.
- Immediate extension:
  - sign_ext=1: upper 16 bits = imm[15].
  - sign_ext=0: upper 16 bits = 0.
  - use_imm=1: alu_b = extended imm, and B forwarding is ignored.
- Pass-through: alu_control = captured alu_op; out_rd_addr = captured rd_addr.
- Forwarding sources are sampled only in the capture cycle. A stalled, held instruction does not re-resolve its operands. Decode must not advance a dependent instruction while it is stalled upstream of a producer.

Optional Feature:
- Macro: EX_FORWARD_EN.
- Defined: forwarding muxes as above.
- Undefined: alu_a = rs_data and alu_b = rt_data/imm directly. The mem_* and wb_* inputs are left unused, and software/hazard logic must insert bubbles.
- Handshake and timing are identical in both builds.

Test Plan:
- Reset with rst=1 mid-cycle, asynchronous → out_valid=0, alu_a=alu_b=0 immediately, without waiting for a clock edge.
- Accept rs_data=5, rt_data=3, alu_op=11, out_ready=1 → next cycle out_valid=1, alu_a=5, alu_b=3, alu_control=11.
- Forwarding (EX_FORWARD_EN defined):
  - rs_addr=rt_addr=4, mem_we=1, mem_waddr=4, mem_wdata=0xAA, wb_we=1, wb_waddr=4, wb_wdata=0xBB, rs_data=1 → alu_a=alu_b=0xAA.
  - Same with rs_addr=0 → alu_a=1.
- Immediate: use_imm=1, imm=0xFFFE.
  - sign_ext=1 → alu_b=0xFFFFFFFE.
  - sign_ext=0 → alu_b=0x0000FFFE.
- Stall: out_valid=1, out_ready=0 for 3 cycles with new in_valid → in_ready=0 and outputs unchanged. Then out_ready=1 → new instruction captured next edge with no gap.
- Flush while out_valid=1 and in_valid=1 → next cycle out_valid=0 and the offered instruction is not captured.

Source files
------------

// File: rtl/ex_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module      : ex_operand_stage
//  Description : ID/EX pipeline register in front of the 32-bit ALU. It
//                captures the decoded operands, resolves EX/MEM and MEM/WB
//                forwarding, extends the immediate, and registers alu_a,
//                alu_b and alu_control behind a valid/ready handshake with
//                flush support.
//  Options     : EX_FORWARD_EN - when defined, forwarding muxes are built;
//                when undefined, operands come straight from the register
//                file and the mem_*/wb_* inputs are unused.
//  Revision    : 1.0 - initial release
// ============================================================================
module ex_operand_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int IMM_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_AW-1:0] rs_addr,
    input  logic [REG_AW-1:0] rt_addr,
    input  logic [REG_AW-1:0] rd_addr,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    input  logic [IMM_W-1:0]  imm,
    input  logic              use_imm,
    input  logic              sign_ext,
    input  logic [1:0]        alu_op,
    input  logic              flush,
    input  logic              mem_we,
    input  logic [REG_AW-1:0] mem_waddr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_waddr,
    input  logic [DATA_W-1:0] wb_wdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [1:0]        alu_control,
    output logic [REG_AW-1:0] out_rd_addr
);

    localparam int c_EXT_W = DATA_W - IMM_W;

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d;
    logic [DATA_W-1:0] alu_b_q, alu_b_d;
    logic [1:0]        alu_control_q, alu_control_d;
    logic [REG_AW-1:0] rd_addr_q, rd_addr_d;

    logic [DATA_W-1:0] fwd_a;
    logic [DATA_W-1:0] fwd_b;
    logic [DATA_W-1:0] imm_ext;
    logic              accept;

    // A slot is free when it is empty or its contents leave this cycle.
    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;

`ifdef EX_FORWARD_EN
    // Operand forwarding: EX/MEM wins over MEM/WB; register 0 never forwards.
    always_comb begin
        fwd_a = rs_data;
        fwd_b = rt_data;
        if (rs_addr != '0 && mem_we && mem_waddr == rs_addr)
            fwd_a = mem_wdata;
        else if (rs_addr != '0 && wb_we && wb_waddr == rs_addr)
            fwd_a = wb_wdata;
        if (rt_addr != '0 && mem_we && mem_waddr == rt_addr)
            fwd_b = mem_wdata;
        else if (rt_addr != '0 && wb_we && wb_waddr == rt_addr)
            fwd_b = wb_wdata;
    end
`else
    // Without forwarding the hazard logic upstream inserts bubbles, so the
    // register-file data is used as-is and the bypass inputs are ignored.
    logic unused_bypass;
    assign fwd_a = rs_data;
    assign fwd_b = rt_data;
    assign unused_bypass = ^{mem_we, mem_waddr, mem_wdata,
                             wb_we, wb_waddr, wb_wdata};
`endif

    // Immediate widening: replicate imm MSB for signed forms, zeros otherwise.
    always_comb begin
        imm_ext = {{c_EXT_W{1'b0}}, imm};
        if (sign_ext)
            imm_ext = {{c_EXT_W{imm[IMM_W-1]}}, imm};
    end

    // Next-state: capture on an accepted, non-flushed transfer; else hold.
    always_comb begin
        valid_d       = valid_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        alu_control_d = alu_control_q;
        rd_addr_d     = rd_addr_q;

        if (flush)
            valid_d = 1'b0;
        else if (accept)
            valid_d = 1'b1;
        else if (out_ready)
            valid_d = 1'b0;

        if (accept && !flush) begin
            alu_a_d       = fwd_a;
            alu_b_d       = use_imm ? imm_ext : fwd_b;
            alu_control_d = alu_op;
            rd_addr_d     = rd_addr;
        end
    end

    // Pipeline register; reset drops any held instruction immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q       <= 1'b0;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_control_q <= 2'b00;
            rd_addr_q     <= '0;
        end else begin
            valid_q       <= valid_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            alu_control_q <= alu_control_d;
            rd_addr_q     <= rd_addr_d;
        end
    end

    assign out_valid   = valid_q;
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_control = alu_control_q;
    assign out_rd_addr = rd_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ex_operand_stage
//  Description : Directed, table-driven self-checking bench for
//                ex_operand_stage, plus hand-written stall, flush and
//                asynchronous-reset sequences. Expected operand values
//                follow the EX_FORWARD_EN build selection.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_operand_stage;

`ifdef EX_FORWARD_EN
    localparam bit c_FWD = 1'b1;
`else
    localparam bit c_FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  rs_addr, rt_addr, rd_addr;
    logic [31:0] rs_data, rt_data;
    logic [15:0] imm;
    logic        use_imm, sign_ext;
    logic [1:0]  alu_op;
    logic        flush;
    logic        mem_we;
    logic [4:0]  mem_waddr;
    logic [31:0] mem_wdata;
    logic        wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_a, alu_b;
    logic [1:0]  alu_control;
    logic [4:0]  out_rd_addr;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [4:0]  rs, rt, rd;
        logic [31:0] rsd, rtd;
        logic [15:0] im;
        logic        ui, sx;
        logic [1:0]  op;
        logic        mwe;
        logic [4:0]  mwa;
        logic [31:0] mwd;
        logic        wwe;
        logic [4:0]  wwa;
        logic [31:0] wwd;
        logic [31:0] a_fwd, b_fwd, a_raw, b_raw;
    } vec_t;

    vec_t vecs[9];

    ex_operand_stage #(.DATA_W(32), .REG_AW(5), .IMM_W(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr),
        .rs_data(rs_data), .rt_data(rt_data),
        .imm(imm), .use_imm(use_imm), .sign_ext(sign_ext),
        .alu_op(alu_op), .flush(flush),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
        .out_rd_addr(out_rd_addr)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(
        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
        input logic [31:0] rsd, input logic [31:0] rtd, input logic [15:0] im,
        input logic ui, input logic sx, input logic [1:0] op,
        input logic mwe, input logic [4:0] mwa, input logic [31:0] mwd,
        input logic wwe, input logic [4:0] wwa, input logic [31:0] wwd,
        input logic [31:0] a_fwd, input logic [31:0] b_fwd,
        input logic [31:0] a_raw, input logic [31:0] b_raw);
        vec_t v;
        v.rs = rs; v.rt = rt; v.rd = rd; v.rsd = rsd; v.rtd = rtd;
        v.im = im; v.ui = ui; v.sx = sx; v.op = op;
        v.mwe = mwe; v.mwa = mwa; v.mwd = mwd;
        v.wwe = wwe; v.wwa = wwa; v.wwd = wwd;
        v.a_fwd = a_fwd; v.b_fwd = b_fwd; v.a_raw = a_raw; v.b_raw = b_raw;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rs_addr = v.rs; rt_addr = v.rt; rd_addr = v.rd;
        rs_data = v.rsd; rt_data = v.rtd; imm = v.im;
        use_imm = v.ui; sign_ext = v.sx; alu_op = v.op;
        mem_we = v.mwe; mem_waddr = v.mwa; mem_wdata = v.mwd;
        wb_we = v.wwe; wb_waddr = v.wwa; wb_wdata = v.wwd;
    endtask

    // One active edge, then park on the falling edge for sampling/driving.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        // rs rt rd rsd rtd imm ui sx op | mem | wb | a_fwd b_fwd a_raw b_raw
        vecs[0] = mk(5'd1, 5'd2, 5'd3, 32'd5, 32'd3, 16'h0000, 0, 0, 2'b11,
                     0, 5'd0, 32'h0, 0, 5'd0, 32'h0,
                     32'd5, 32'd3, 32'd5, 32'd3);
        vecs[1] = mk(5'd4, 5'd4, 5'd9, 32'd1, 32'd2, 16'h0000, 0, 0, 2'b10,
                     1, 5'd4, 32'hAA, 1, 5'd4, 32'hBB,
                     32'hAA, 32'hAA, 32'd1, 32'd2);
        vecs[2] = mk(5'd0, 5'd4, 5'd10, 32'd1, 32'd2, 16'h0000, 0, 0, 2'b01,
                     1, 5'd4, 32'hAA, 1, 5'd4, 32'hBB,
                     32'd1, 32'hAA, 32'd1, 32'd2);
        vecs[3] = mk(5'd7, 5'd8, 5'd11, 32'h10, 32'h20, 16'h0000, 0, 0, 2'b00,
                     1, 5'd9, 32'hCC, 1, 5'd7, 32'hBB,
                     32'hBB, 32'h20, 32'h10, 32'h20);
        vecs[4] = mk(5'd3, 5'd3, 5'd12, 32'h30, 32'h31, 16'h0000, 0, 0, 2'b10,
                     0, 5'd3, 32'hDD, 0, 5'd3, 32'hEE,
                     32'h30, 32'h31, 32'h30, 32'h31);
        vecs[5] = mk(5'd6, 5'd4, 5'd13, 32'h40, 32'h41, 16'hFFFE, 1, 1, 2'b11,
                     1, 5'd4, 32'hAA, 0, 5'd0, 32'h0,
                     32'h40, 32'hFFFFFFFE, 32'h40, 32'hFFFFFFFE);
        vecs[6] = mk(5'd6, 5'd4, 5'd14, 32'h50, 32'h51, 16'hFFFE, 1, 0, 2'b01,
                     1, 5'd4, 32'hAA, 0, 5'd0, 32'h0,
                     32'h50, 32'h0000FFFE, 32'h50, 32'h0000FFFE);
        vecs[7] = mk(5'd2, 5'd2, 5'd15, 32'h60, 32'h61, 16'h7FFF, 1, 1, 2'b00,
                     0, 5'd0, 32'h0, 1, 5'd2, 32'h77,
                     32'h77, 32'h00007FFF, 32'h60, 32'h00007FFF);
        vecs[8] = mk(5'd5, 5'd0, 5'd31, 32'h70, 32'h71, 16'h0000, 0, 0, 2'b10,
                     1, 5'd0, 32'h99, 1, 5'd0, 32'h98,
                     32'h70, 32'h71, 32'h70, 32'h71);

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
        drive(vecs[0]);
        #1;
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_alu_a", alu_a, 32'd0);
        check("reset_alu_b", alu_b, 32'd0);
        check("reset_alu_control", {30'd0, alu_control}, 32'd0);
        check("reset_rd_addr", {27'd0, out_rd_addr}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Back-to-back vectors with a consuming sink: one result per cycle.
        for (int i = 0; i < 9; i++) begin
            drive(vecs[i]);
            in_valid = 1'b1;
            #1;
            check($sformatf("v%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
            tick();
            check($sformatf("v%0d_out_valid", i), {31'd0, out_valid}, 32'd1);
            check($sformatf("v%0d_alu_a", i), alu_a,
                  c_FWD ? vecs[i].a_fwd : vecs[i].a_raw);
            check($sformatf("v%0d_alu_b", i), alu_b,
                  c_FWD ? vecs[i].b_fwd : vecs[i].b_raw);
            check($sformatf("v%0d_alu_control", i), {30'd0, alu_control},
                  {30'd0, vecs[i].op});
            check($sformatf("v%0d_rd_addr", i), {27'd0, out_rd_addr},
                  {27'd0, vecs[i].rd});
        end

        // Stall: hold vecs[0] for three cycles while vecs[4] is offered.
        drive(vecs[0]);
        tick();
        check("stall_load_a", alu_a, 32'd5);
        drive(vecs[4]);
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("stall%0d_in_ready", c), {31'd0, in_ready}, 32'd0);
            tick();
            check($sformatf("stall%0d_out_valid", c), {31'd0, out_valid}, 32'd1);
            check($sformatf("stall%0d_alu_a", c), alu_a, 32'd5);
            check($sformatf("stall%0d_alu_b", c), alu_b, 32'd3);
            check($sformatf("stall%0d_ctl", c), {30'd0, alu_control}, 32'd3);
        end
        out_ready = 1'b1;
        #1;
        check("release_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        check("release_out_valid", {31'd0, out_valid}, 32'd1);
        check("release_alu_a", alu_a, 32'h30);
        check("release_rd_addr", {27'd0, out_rd_addr}, 32'd12);
        in_valid = 1'b0;
        tick();
        check("drain_out_valid", {31'd0, out_valid}, 32'd0);

        // Flush with an instruction held and another offered.
        drive(vecs[0]);
        in_valid = 1'b1;
        tick();
        check("preflush_out_valid", {31'd0, out_valid}, 32'd1);
        drive(vecs[3]);
        flush = 1'b1;
        #1;
        check("flush_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        check("flush_out_valid", {31'd0, out_valid}, 32'd0);
        flush = 1'b0;
        in_valid = 1'b0;
        tick();
        check("postflush_out_valid", {31'd0, out_valid}, 32'd0);

        // Flush while stalled drops the held instruction.
        drive(vecs[0]);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        out_ready = 1'b0;
        flush = 1'b1;
        tick();
        check("stallflush_out_valid", {31'd0, out_valid}, 32'd0);
        flush = 1'b0;
        out_ready = 1'b1;

        // Asynchronous reset asserted between edges clears outputs at once.
        drive(vecs[3]);
        in_valid = 1'b1;
        tick();
        check("prereset_out_valid", {31'd0, out_valid}, 32'd1);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("async_out_valid", {31'd0, out_valid}, 32'd0);
        check("async_alu_a", alu_a, 32'd0);
        check("async_alu_b", alu_b, 32'd0);
        check("async_rd_addr", {27'd0, out_rd_addr}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("after_reset_out_valid", {31'd0, out_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
